// File: rtl/isa_dsp_target_if.sv
// isa_dsp_target_if: ISA I/O + DMA bus and local byte stream between a bus master and the card target
interface isa_dsp_target_if;
    logic [15:0] isa_a;
    logic        isa_aen;
    logic [7:0]  isa_d_in;
    logic [7:0]  isa_d_out;
    logic        isa_d_oe;
    logic        isa_ior_n;
    logic        isa_iow_n;
    logic        isa_dack_n;
    logic        isa_drq;
    logic        isa_irq;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    modport master (
        output isa_a, isa_aen, isa_d_in, isa_ior_n, isa_iow_n, isa_dack_n, out_ready,
        input  isa_d_out, isa_d_oe, isa_drq, isa_irq, out_data, out_valid
    );
    modport slave (
        input  isa_a, isa_aen, isa_d_in, isa_ior_n, isa_iow_n, isa_dack_n, out_ready,
        output isa_d_out, isa_d_oe, isa_drq, isa_irq, out_data, out_valid
    );
endinterface

// File: rtl/isa_dsp_target.sv
// isa_dsp_target: ISA I/O register target with single-mode DMA write into a byte FIFO.
// Optional ISA_DSP_TARGET_STATE_OUT_EN exposes the FSM state as state_out[3:0].
module isa_dsp_target #(
    parameter logic [15:0] BASE_ADDR  = 16'h0220,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    isa_dsp_target_if.slave bus
`ifdef ISA_DSP_TARGET_STATE_OUT_EN
    ,
    output logic [3:0]     state_out
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [2:0] IDLE = 3'd0, IO_RD = 3'd1, IO_WR = 3'd2, DMA_WR = 3'd3, RECOVER = 3'd4;

    // strobe sync order {dack_n, iow_n, ior_n}; bus sync order {aen, a, d}
    logic [2:0]  stb_m_q, stb_s_q;
    logic [24:0] bus_m_q, bus_s_q;
    logic [2:0]  state_q, state_d;
    logic        first_q, first_d;
    logic [3:0]  off_q, off_d;
    logic [7:0]  dat_q, dat_d;
    logic        dma_en_q, dma_en_d, irq_en_q, irq_en_d, irq_pend_q, irq_pend_d, ovf_q, ovf_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  scratch_q, scratch_d, d_out_q, d_out_d, rd_mux;
    logic        oe_q, oe_d, drq_q, drq_d, irq_q, irq_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        ior, iow, dack, hit, empty, full, pop, wr, push, push_ok;

    assign ior     = ~stb_s_q[0];
    assign iow     = ~stb_s_q[1];
    assign dack    = ~stb_s_q[2];
    assign hit     = ~bus_s_q[24] & (bus_s_q[23:12] == BASE_ADDR[15:4]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = level == '0;
    assign full    = level == DEPTH;
    assign pop     = ~empty & bus.out_ready;
    assign wr      = (state_q == IO_WR) & first_q;
    assign push    = (state_q == DMA_WR) & first_q;
    assign push_ok = push & (~full | pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:
                if (dack & iow) state_d = DMA_WR;
                else if (ior & ~iow & ~dack & hit) state_d = IO_RD;
                else if (iow & ~ior & ~dack & hit) state_d = IO_WR;
                else if (ior | iow | dack) state_d = RECOVER;
            IO_RD:   state_d = ior ? IO_RD : IDLE;
            IO_WR:   state_d = iow ? IO_WR : IDLE;
            DMA_WR:  state_d = (iow | dack) ? DMA_WR : IDLE;
            default: state_d = (ior | iow | dack) ? RECOVER : IDLE;
        endcase
        // address and data are latched on the IDLE exit edge; the action happens one cycle later
        first_d = (state_q == IDLE) & (state_d != IDLE);
        off_d   = first_d ? bus_s_q[11:8] : off_q;
        dat_d   = first_d ? bus_s_q[7:0] : dat_q;
    end

    always_comb begin
        dma_en_d   = dma_en_q;
        irq_en_d   = irq_en_q;
        irq_pend_d = irq_pend_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        if (wr) begin
            case (off_q)
                4'd0: {irq_en_d, dma_en_d} = dat_q[1:0];
                4'd1: cnt_d[7:0] = dat_q;
                4'd2: cnt_d[15:8] = dat_q;
                4'd3: begin
                    irq_pend_d = irq_pend_q & ~dat_q[0];
                    ovf_d      = ovf_q & ~dat_q[1];
                end
                4'd4: scratch_d = dat_q;
                default: ;
            endcase
        end
        if (push) begin
            dma_en_d   = (cnt_q == 16'd0) ? 1'b0 : dma_en_q;
            irq_pend_d = (cnt_q == 16'd0) | irq_pend_q;
            cnt_d      = (cnt_q == 16'd0) ? cnt_q : cnt_q - 16'd1;
            ovf_d      = ovf_q | ~push_ok;
        end
        wr_ptr_d = wr_ptr_q + (AW + 1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
        rd_mux   = off_d == 4'd0 ? {6'd0, irq_en_q, dma_en_q} :
                   off_d == 4'd1 ? cnt_q[7:0] :
                   off_d == 4'd2 ? cnt_q[15:8] :
                   off_d == 4'd3 ? {dma_en_q, 3'd0, full, empty, ovf_q, irq_pend_q} :
                   off_d == 4'd4 ? scratch_q : 8'hFF;
        oe_d     = state_d == IO_RD;
        d_out_d  = oe_d ? rd_mux : 8'h00;
        drq_d    = dma_en_q & ~full & (state_q == IDLE) & ~dack;
        irq_d    = irq_pend_q & irq_en_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stb_m_q    <= '1;
            stb_s_q    <= '1;
            bus_m_q    <= '0;
            bus_s_q    <= '0;
            state_q    <= IDLE;
            first_q    <= 1'b0;
            off_q      <= '0;
            dat_q      <= '0;
            dma_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            scratch_q  <= '0;
            d_out_q    <= '0;
            oe_q       <= 1'b0;
            drq_q      <= 1'b0;
            irq_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            stb_m_q    <= {bus.isa_dack_n, bus.isa_iow_n, bus.isa_ior_n};
            stb_s_q    <= stb_m_q;
            bus_m_q    <= {bus.isa_aen, bus.isa_a, bus.isa_d_in};
            bus_s_q    <= bus_m_q;
            state_q    <= state_d;
            first_q    <= first_d;
            off_q      <= off_d;
            dat_q      <= dat_d;
            dma_en_q   <= dma_en_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            d_out_q    <= d_out_d;
            oe_q       <= oe_d;
            drq_q      <= drq_d;
            irq_q      <= irq_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= dat_q;
    end

    assign bus.isa_d_out = d_out_q;
    assign bus.isa_d_oe  = oe_q;
    assign bus.isa_drq   = drq_q;
    assign bus.isa_irq   = irq_q;
    assign bus.out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.out_valid = ~empty;
`ifdef ISA_DSP_TARGET_STATE_OUT_EN
    assign state_out = {1'b0, state_q};
`endif
endmodule
